// File: rtl/pc_pkg.sv
// Shared constants and the redirect-select encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned     PC_W_DEF    = 16;
    localparam logic [15:0]     RST_VEC_DEF = 16'h0000;
    localparam logic [15:0]     INT_VEC_DEF = 16'h0010;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_RETI,
        SEL_INT
    } redir_sel_e;

endpackage

// File: rtl/pc_stage_reg.sv
// One PC+INC / valid pipeline stage with flush, stall and bubble insertion.
module pc_stage_reg #(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            bubble,
    input  logic [PC_W-1:0] pc_in,
    input  logic            vld_in,
    output logic [PC_W-1:0] pc_q,
    output logic            vld_q
);

    // Flush outranks stall; on flush or bubble the PC field simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (!stall) begin
            if (bubble) begin
                vld_q <= 1'b0;
            end else begin
                pc_q  <= pc_in;
                vld_q <= vld_in;
            end
        end
    end

endmodule

// File: rtl/pc_pipe.sv
// Fetch program counter with branch/interrupt/reti redirect and a stallable PC+INC pipeline.
module pc_pipe
    import pc_pkg::*;
#(
    parameter int unsigned      PC_W    = PC_W_DEF,
    parameter int unsigned      NUM_STG = 3,
    parameter int unsigned      INC     = 1,
    parameter logic [PC_W-1:0]  RST_VEC = PC_W'(RST_VEC_DEF),
    parameter logic [PC_W-1:0]  INT_VEC = PC_W'(INT_VEC_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_STG-1:0]      stall_stg,
    input  logic [NUM_STG-1:0]      flush_stg,
    input  logic                    flow_change,
    input  logic [PC_W-1:0]         dst,
    input  logic                    reti,
    input  logic                    ei,
    input  logic                    int_req,
    output logic [PC_W-1:0]         pc,
    output logic [NUM_STG*PC_W-1:0] pc_stg,
    output logic [NUM_STG-1:0]      vld_stg,
    output logic [PC_W-1:0]         epc,
    output logic                    int_en,
    output logic                    int_ack
);

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] alt_pc;
    logic            int_take;
    redir_sel_e      sel;

    logic [PC_W-1:0] stg_pc [NUM_STG];
    logic [NUM_STG-1:0] stg_vld;

    assign seq      = pc + PC_W'(INC);
    assign int_take = int_req & int_en & ~stall_stg[0];

    // alt_pc is where fetch would have gone had the interrupt not been taken.
    always_comb begin
        alt_pc = seq;
        if (reti)
            alt_pc = epc;
        else if (flow_change)
            alt_pc = dst;
    end

    always_comb begin
        sel = SEL_SEQ;
        if (int_take)
            sel = SEL_INT;
        else if (reti)
            sel = SEL_RETI;
        else if (flow_change)
            sel = SEL_BR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RST_VEC;
            epc     <= '0;
            int_en  <= 1'b0;
            int_ack <= 1'b0;
        end else begin
            int_ack <= int_take;
            if (!stall_stg[0]) begin
                case (sel)
                    SEL_INT: begin
                        pc  <= INT_VEC;
                        epc <= alt_pc;
                    end
                    SEL_RETI: pc <= epc;
                    SEL_BR:   pc <= dst;
                    default:  pc <= seq;
                endcase
            end
            // ei works even under stall, but an accepted interrupt always clears.
            if (int_take)
                int_en <= 1'b0;
            else if (ei || (!stall_stg[0] && reti))
                int_en <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
        logic [PC_W-1:0] pc_in;
        logic            vld_in;
        logic            bubble;

        if (k == 0) begin : g_first
            assign pc_in  = seq;
            assign vld_in = 1'b1;
            assign bubble = 1'b0;
        end else begin : g_rest
            assign pc_in  = stg_pc[k-1];
            assign vld_in = stg_vld[k-1];
            assign bubble = stall_stg[k-1];
        end

        pc_stage_reg #(.PC_W(PC_W)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .stall  (stall_stg[k]),
            .flush  (flush_stg[k]),
            .bubble (bubble),
            .pc_in  (pc_in),
            .vld_in (vld_in),
            .pc_q   (stg_pc[k]),
            .vld_q  (stg_vld[k])
        );

        assign pc_stg[k*PC_W +: PC_W] = stg_pc[k];
    end

    assign vld_stg = stg_vld;

endmodule

// File: tb/tb_pc_pipe.sv
// Directed bench for pc_pipe: reset, stalled redirect, interrupts, wrap and flush priority.
module tb_pc_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  stall_stg = '0;
    logic [2:0]  flush_stg = '0;
    logic        flow_change = 1'b0;
    logic [15:0] dst = '0;
    logic        reti = 1'b0;
    logic        ei = 1'b0;
    logic        int_req = 1'b0;
    logic [15:0] pc;
    logic [47:0] pc_stg;
    logic [2:0]  vld_stg;
    logic [15:0] epc;
    logic        int_en;
    logic        int_ack;

    logic        fc8 = 1'b0;
    logic [7:0]  dst8 = '0;
    logic [7:0]  pc8;
    logic [23:0] pc_stg8;
    logic [2:0]  vld_stg8;
    logic [7:0]  epc8;
    logic        int_en8;
    logic        int_ack8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_pipe dut (
        .clk(clk), .rst_n(rst_n), .stall_stg(stall_stg), .flush_stg(flush_stg),
        .flow_change(flow_change), .dst(dst), .reti(reti), .ei(ei), .int_req(int_req),
        .pc(pc), .pc_stg(pc_stg), .vld_stg(vld_stg), .epc(epc), .int_en(int_en),
        .int_ack(int_ack)
    );

    pc_pipe #(.PC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall_stg(3'b000), .flush_stg(3'b000),
        .flow_change(fc8), .dst(dst8), .reti(1'b0), .ei(1'b0), .int_req(1'b0),
        .pc(pc8), .pc_stg(pc_stg8), .vld_stg(vld_stg8), .epc(epc8), .int_en(int_en8),
        .int_ack(int_ack8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall_stg = '0; flush_stg = '0; flow_change = 1'b0; dst = '0;
        reti = 1'b0; ei = 1'b0; int_req = 1'b0; fc8 = 1'b0; dst8 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] exp_pc [4] = '{16'h0, 16'h1, 16'h2, 16'h3};
        logic [2:0]  exp_v  [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_cmp++; if (pc !== 16'h0) begin n_err++; $display("FAIL rst_pc: got %h exp 0000", pc); end
        n_cmp++; if (pc_stg !== 48'h0) begin n_err++; $display("FAIL rst_pc_stg: got %h exp 0", pc_stg); end
        n_cmp++; if (vld_stg !== 3'b000) begin n_err++; $display("FAIL rst_vld: got %b exp 000", vld_stg); end
        n_cmp++; if ({epc, int_en, int_ack} !== 18'h0) begin n_err++; $display("FAIL rst_epc_int: got %h/%b/%b exp 0/0/0", epc, int_en, int_ack); end
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pc !== exp_pc[i]) begin n_err++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, pc, exp_pc[i]); end
            n_cmp++; if (vld_stg !== exp_v[i]) begin n_err++; $display("FAIL seq_vld[%0d]: got %b exp %b", i, vld_stg, exp_v[i]); end
            if (i < 3) tick();
        end
        n_cmp++; if (pc_stg !== {16'h1, 16'h2, 16'h3}) begin n_err++; $display("FAIL seq_stg: got %h exp 000100020003", pc_stg); end
    endtask

    task automatic test_redirect_stall();
        apply_reset();
        repeat (5) tick();
        n_cmp++; if (pc !== 16'h5) begin n_err++; $display("FAIL rs_pre_pc: got %h exp 0005", pc); end
        flow_change = 1'b1; dst = 16'h0040; stall_stg = 3'b001;
        tick();
        n_cmp++; if (pc !== 16'h5) begin n_err++; $display("FAIL rs_hold1: got %h exp 0005", pc); end
        n_cmp++; if (vld_stg !== 3'b101) begin n_err++; $display("FAIL rs_vld1: got %b exp 101", vld_stg); end
        n_cmp++; if (pc_stg[15:0] !== 16'h5) begin n_err++; $display("FAIL rs_stg0_hold: got %h exp 0005", pc_stg[15:0]); end
        tick();
        n_cmp++; if (pc !== 16'h5) begin n_err++; $display("FAIL rs_hold2: got %h exp 0005", pc); end
        n_cmp++; if (vld_stg !== 3'b001) begin n_err++; $display("FAIL rs_vld2: got %b exp 001", vld_stg); end
        stall_stg = 3'b000;
        tick();
        n_cmp++; if (pc !== 16'h0040) begin n_err++; $display("FAIL rs_redir: got %h exp 0040", pc); end
        n_cmp++; if (pc_stg[31:0] !== {16'h5, 16'h6}) begin n_err++; $display("FAIL rs_stg01: got %h exp 00050006", pc_stg[31:0]); end
        n_cmp++; if (vld_stg !== 3'b011) begin n_err++; $display("FAIL rs_vld3: got %b exp 011", vld_stg); end
        flow_change = 1'b0;
        tick();
        n_cmp++; if (pc !== 16'h0041) begin n_err++; $display("FAIL rs_after: got %h exp 0041", pc); end
    endtask

    task automatic test_int_branch();
        apply_reset();
        int_req = 1'b1;
        tick();
        n_cmp++; if (pc !== 16'h1 || int_ack !== 1'b0) begin n_err++; $display("FAIL ib_disabled: got pc %h ack %b exp 0001 0", pc, int_ack); end
        int_req = 1'b0; ei = 1'b1;
        tick();
        ei = 1'b0;
        n_cmp++; if (int_en !== 1'b1) begin n_err++; $display("FAIL ib_ei: got %b exp 1", int_en); end
        int_req = 1'b1; flow_change = 1'b1; dst = 16'h0100; stall_stg = 3'b001;
        tick();
        n_cmp++; if (pc !== 16'h2 || int_ack !== 1'b0 || int_en !== 1'b1) begin n_err++; $display("FAIL ib_stalled: got pc %h ack %b en %b exp 0002 0 1", pc, int_ack, int_en); end
        stall_stg = 3'b000;
        tick();
        n_cmp++; if (pc !== 16'h0010) begin n_err++; $display("FAIL ib_pc: got %h exp 0010", pc); end
        n_cmp++; if (epc !== 16'h0100) begin n_err++; $display("FAIL ib_epc: got %h exp 0100", epc); end
        n_cmp++; if (int_en !== 1'b0 || int_ack !== 1'b1) begin n_err++; $display("FAIL ib_en_ack: got %b/%b exp 0/1", int_en, int_ack); end
        int_req = 1'b0; flow_change = 1'b0;
        tick();
        n_cmp++; if (int_ack !== 1'b0 || pc !== 16'h0011) begin n_err++; $display("FAIL ib_ack_pulse: got ack %b pc %h exp 0 0011", int_ack, pc); end
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_cmp++; if (pc !== 16'h0100 || int_en !== 1'b1) begin n_err++; $display("FAIL ib_reti: got pc %h en %b exp 0100 1", pc, int_en); end
        stall_stg = 3'b001; ei = 1'b0;
        tick();
        stall_stg = 3'b000;
        n_cmp++; if (pc !== 16'h0100) begin n_err++; $display("FAIL ib_hold: got %h exp 0100", pc); end
    endtask

    task automatic test_int_beats_reti();
        apply_reset();
        ei = 1'b1;
        tick();
        ei = 1'b0; int_req = 1'b1; flow_change = 1'b1; dst = 16'h0123;
        tick();
        int_req = 1'b0; flow_change = 1'b0;
        n_cmp++; if (epc !== 16'h0123) begin n_err++; $display("FAIL ir_setup_epc: got %h exp 0123", epc); end
        ei = 1'b1; stall_stg = 3'b001;
        tick();
        ei = 1'b0; stall_stg = 3'b000;
        n_cmp++; if (int_en !== 1'b1) begin n_err++; $display("FAIL ir_ei_stalled: got %b exp 1", int_en); end
        reti = 1'b1; int_req = 1'b1;
        tick();
        reti = 1'b0; int_req = 1'b0;
        n_cmp++; if (pc !== 16'h0010) begin n_err++; $display("FAIL ir_pc: got %h exp 0010", pc); end
        n_cmp++; if (epc !== 16'h0123) begin n_err++; $display("FAIL ir_epc: got %h exp 0123", epc); end
        n_cmp++; if (int_en !== 1'b0 || int_ack !== 1'b1) begin n_err++; $display("FAIL ir_en_ack: got %b/%b exp 0/1", int_en, int_ack); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (int_ack !== 1'b0 || pc !== 16'h0 || epc !== 16'h0) begin n_err++; $display("FAIL ir_mid_rst: got ack %b pc %h epc %h exp 0 0000 0000", int_ack, pc, epc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        apply_reset();
        fc8 = 1'b1; dst8 = 8'hFF;
        tick();
        fc8 = 1'b0;
        n_cmp++; if (pc8 !== 8'hFF) begin n_err++; $display("FAIL wrap_load: got %h exp ff", pc8); end
        tick();
        n_cmp++; if (pc8 !== 8'h00) begin n_err++; $display("FAIL wrap_pc: got %h exp 00", pc8); end
        n_cmp++; if (pc_stg8[7:0] !== 8'h00) begin n_err++; $display("FAIL wrap_stg0: got %h exp 00", pc_stg8[7:0]); end
    endtask

    task automatic test_flush_stall();
        apply_reset();
        repeat (3) tick();
        flush_stg = 3'b010; stall_stg = 3'b011;
        tick();
        flush_stg = 3'b000; stall_stg = 3'b000;
        n_cmp++; if (vld_stg !== 3'b001) begin n_err++; $display("FAIL fs_vld: got %b exp 001", vld_stg); end
        n_cmp++; if (pc_stg[15:0] !== 16'h3 || pc !== 16'h3) begin n_err++; $display("FAIL fs_hold: got stg0 %h pc %h exp 0003 0003", pc_stg[15:0], pc); end
        tick();
        n_cmp++; if (vld_stg !== 3'b011 || pc_stg[31:16] !== 16'h3) begin n_err++; $display("FAIL fs_resume: got %b stg1 %h exp 011 0003", vld_stg, pc_stg[31:16]); end
    endtask

    initial begin
        test_reset();
        test_redirect_stall();
        test_int_branch();
        test_int_beats_reti();
        test_wrap();
        test_flush_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_pipe.md
# pc_pipe

Parametrised program-counter unit for the pipelined CPU. It generates the fetch address, redirects on taken branches/jumps, on an external interrupt and on return-from-interrupt. It also carries the PC+INC value and a valid bit down a configurable number of pipeline stages, with per-stage stall and flush. It sits at the front of fetch and feeds instruction memory, the branch adder (EX) and the JAL/EPC destination mux.

## Interface
- PC_W, 16, PC/address width
- NUM_STG, 3, number of PC pipeline stages after fetch (stage 0 = IM_ID), ≥1
- INC, 1, sequential increment
- RST_VEC, 0, PC value after reset (PC_W bits)
- INT_VEC, 16'h0010, interrupt handler address (PC_W bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_stg  in  NUM_STG  bit k holds stage k; bit 0 also holds the PC; upstream guarantees stall_stg[k] implies stall_stg[j] for all j<k
- flush_stg  in  NUM_STG  bit k invalidates stage k
- flow_change  in  1  taken branch/jump
- dst  in  PC_W  branch/jump target
- reti  in  1  return from interrupt
- ei  in  1  set interrupt enable
- int_req  in  1  level interrupt request
- pc  out  PC_W  fetch address
- pc_stg  out  NUM_STG*PC_W  flattened; slice k = stage k PC+INC
- vld_stg  out  NUM_STG  stage valid bits
- epc  out  PC_W  saved return address
- int_en  out  1  interrupt enable
- int_ack  out  1  one-cycle pulse on interrupt acceptance

## Operation
- Candidate next PC (seq) = pc + INC, modulo 2^PC_W: all-ones+1 wraps to 0.
- A redirect acts only when stall_stg[0]=0. While stall_stg[0]=1, pc, epc and int_en hold, and flow_change, reti and int_req are ignored. Upstream holds these inputs until the stall clears.
- Priority when not stalled:
  1. Interrupt (int_req & int_en): pc<=INT_VEC; epc<=the PC that would otherwise be loaded (dst if flow_change, epc if reti, else seq); int_en<=0; int_ack=1.
  2. reti: pc<=epc; int_en<=1.
  3. flow_change: pc<=dst.
  4. Otherwise pc<=seq.
- If reti and interrupt coincide, the interrupt wins and int_en stays 0.
- ei sets int_en<=1 regardless of stall, unless an interrupt is accepted the same cycle.
- Stage 0:
  - flush_stg[0]: vld<=0.
  - Else if !stall_stg[0]: pc_stg[0]<=seq, vld<=1.
  - Else hold.
- Stage k>0:
  - flush_stg[k]: vld<=0, PC field don't-care and held.
  - Else if !stall_stg[k] and stall_stg[k-1]: bubble, vld<=0.
  - Else if !stall_stg[k]: copy stage k-1 PC and vld.
  - Else hold.
- Flush has priority over stall.
- The unit does no wrong-path squashing of its own; the hazard unit drives flush_stg.

## Timing
- Reset (async):
  - pc=RST_VEC
  - pc_stg=0
  - vld_stg=0
  - epc=0
  - int_en=0
  - int_ack=0
- int_ack is registered: high in the cycle after acceptance, when pc=INT_VEC.
- PC update latency: 1 cycle from a redirect input to pc.
- Stage k reflects a fetch k+1 cycles later when unstalled.
- After reset deasserts, the first fetch is at RST_VEC. Stage 0 becomes valid on the first unstalled edge.
- Reset mid-operation clears all state immediately, including a pending int_ack.

## Structure
- Package pc_pkg: default PC_W, RST_VEC and INT_VEC constants; redirect-select enum {SEL_SEQ, SEL_BR, SEL_RETI, SEL_INT}.
- Sub-module pc_stage_reg:
  - one PC+valid stage register with stall, flush and bubble inputs;
  - instantiated NUM_STG times by generate.
- Top level holds the PC, epc and int_en registers plus the priority mux.

## Test plan
- Reset, no stalls, NUM_STG=3: pc steps 0,1,2,…; pc_stg slice 2 = 1 in the 4th cycle after reset release, vld_stg=3'b111 from then.
- Redirect under stall: pc=0x0005, flow_change=1, dst=0x0040 with stall_stg=3'b001 for 2 cycles, then released → pc holds 0x0005 for 2 cycles, then 0x0040. Stage 1 shows bubbles (vld=0) during the stall.
- Interrupt on branch: ei pulse, then int_req=1 with flow_change=1, dst=0x0100 → pc=0x0010, epc=0x0100, int_en=0, int_ack one cycle. Later reti → pc=0x0100, int_en=1.
- Interrupt beats reti: reti and int_req both high with int_en=1, epc=0x0123 → pc=0x0010, epc=0x0123, int_en=0.
- Wrap: PC_W=8, pc=0xFF → pc=0x00, pc_stg[0]=0x00.
- Flush beats stall: flush_stg=3'b010 with stall_stg=3'b011 → vld_stg[1]=0 next cycle, stage 0 holds valid.
